reg_load_arbiter: RTL and testbench



---
 rtl/reg_load_arbiter.sv | 99 +++++++++
 tb/tb_reg_load_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin arbiter and load sequencer for a shared WIDTH-bit register.
// Ports: clk/rst (async active-high); req/din from N_REQ requesters; ack one-hot during LOAD;
//        A = shared register, owner = last loader index, busy = LOAD or HOLD in progress.
// Latency: req seen in IDLE -> ack next cycle -> A updates at end of ack cycle; loads spaced 2+HOLD_CYC.
module reg_load_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   din,
  output logic [N_REQ-1:0]         ack,
  output logic [WIDTH-1:0]         A,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int PW = $clog2(N_REQ);
  // Counter is loaded with HOLD_CYC-1 so that exactly HOLD_CYC HOLD cycles elapse.
  localparam logic [3:0] CNT_INIT = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gsel;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   idx;
  logic            found;
  logic [3:0]      cnt;
  logic            load;

  // Circular search starting at ptr; N_REQ is a power of 2 so PW-bit wrap is the modulo.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + PW'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ack       = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (found) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        busy      = 1'b1;
        ack[gsel] = 1'b1;
        state_nxt = (HOLD_CYC > 0) ? HOLD : IDLE;
      end
      HOLD: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is frozen in gsel on entry to LOAD; the load happens even if req[gsel] drops meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gsel  <= '0;
      ptr   <= '0;
      cnt   <= '0;
      A     <= '0;
      owner <= '0;
    end else begin
      if (state == IDLE && found) gsel <= pick;
      if (load) begin
        A     <= din[gsel*WIDTH +: WIDTH];
        owner <= gsel;
        ptr   <= gsel + PW'(1);
        cnt   <= CNT_INIT;
      end else if (state == HOLD && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter: directed bench for reg_load_arbiter (N_REQ=4, WIDTH=4, HOLD_CYC=2).
// Inputs are driven 1ns after the rising edge; outputs are sampled at the same point.
// Each scenario task makes its own comparisons against hand-computed values.
module tb_reg_load_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] din;
  logic [3:0]  ack;
  logic [3:0]  a_out;
  logic [1:0]  owner;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  reg_load_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .ack(ack), .A(a_out), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ack must be at most one-hot and only present while busy
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(ack) || (ack != 4'b0 && !busy)) begin
        failures++;
        $display("FAIL ack_legal ack=%b busy=%b", ack, busy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  // Steps until ack is seen (bounded); a = 0 on timeout.
  task automatic wait_ack(output logic [3:0] a, output int n);
    logic done;
    a = 4'b0; n = 0; done = 1'b0;
    while (!done && n < 12) begin
      step();
      n++;
      if (ack != 4'b0) begin
        a = ack;
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] a; int n;
    #2;
    checks++; if (a_out !== 4'h0) begin failures++; $display("FAIL rst_init_A got=%h exp=0", a_out); end
    checks++; if (ack !== 4'b0) begin failures++; $display("FAIL rst_init_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_init_busy got=%b exp=0", busy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rst_init_owner got=%0d exp=0", owner); end
    step();
    rst = 1'b0;
    req = 4'b1000; din = 16'h9000;
    wait_ack(a, n);
    checks++; if (a !== 4'b1000) begin failures++; $display("FAIL rst_setup_ack got=%b exp=1000", a); end
    req = 4'b0;
    step();
    checks++; if (a_out !== 4'h9 || owner !== 2'd3) begin failures++; $display("FAIL rst_setup_A got=%h/%0d exp=9/3", a_out, owner); end
    // Asynchronous reset during HOLD, checked before any clock edge
    rst = 1'b1;
    #1;
    checks++; if (a_out !== 4'h0) begin failures++; $display("FAIL rst_async_A got=%h exp=0", a_out); end
    checks++; if (ack !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_async_ackbusy got=%b/%b exp=0/0", ack, busy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rst_async_owner got=%0d exp=0", owner); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    req = 4'b0010; din = 16'h00A0;
    checks++; if (ack !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b/%b exp=0/0", ack, busy); end
    step();
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", ack); end
    checks++; if (busy !== 1'b1 || a_out !== 4'h0) begin failures++; $display("FAIL single_load got=%b/%h exp=1/0", busy, a_out); end
    req = 4'b0;
    step();
    checks++; if (ack !== 4'b0) begin failures++; $display("FAIL single_ack_drop got=%b exp=0", ack); end
    checks++; if (a_out !== 4'hA || owner !== 2'd1) begin failures++; $display("FAIL single_A got=%h/%0d exp=A/1", a_out, owner); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_hold1 got=%b exp=1", busy); end
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_hold2 got=%b exp=1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_rotation();
    logic [3:0] a; int n; int last;
    last = 0;
    rst_pulse();
    req = 4'b1111; din = 16'h4321;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, n);
      checks++; if (a !== 4'(1 << k)) begin failures++; $display("FAIL rot_ack%0d got=%b exp=%b", k, a, 4'(1 << k)); end
      if (k > 0) begin
        checks++; if (cyc_cnt - last != 4) begin failures++; $display("FAIL rot_spacing%0d got=%0d exp=4", k, cyc_cnt - last); end
      end
      last = cyc_cnt;
      req[k] = 1'b0;
      step();
      checks++; if (a_out !== 4'(k + 1) || owner !== 2'(k)) begin failures++; $display("FAIL rot_A%0d got=%h/%0d exp=%0d/%0d", k, a_out, owner, k + 1, k); end
    end
  endtask

  task automatic test_fair_wrap();
    logic [3:0] a; int n;
    req = 4'b0100; din = 16'h0600;
    wait_ack(a, n);
    checks++; if (a !== 4'b0100) begin failures++; $display("FAIL wrap_setup_ack got=%b exp=0100", a); end
    req = 4'b0;
    step();
    checks++; if (owner !== 2'd2 || a_out !== 4'h6) begin failures++; $display("FAIL wrap_setup_A got=%h/%0d exp=6/2", a_out, owner); end
    req = 4'b0101; din = 16'h070C;
    wait_ack(a, n);
    checks++; if (a !== 4'b0001) begin failures++; $display("FAIL wrap_first got=%b exp=0001", a); end
    req = 4'b0100;
    step();
    checks++; if (a_out !== 4'hC || owner !== 2'd0) begin failures++; $display("FAIL wrap_first_A got=%h/%0d exp=C/0", a_out, owner); end
    wait_ack(a, n);
    checks++; if (a !== 4'b0100) begin failures++; $display("FAIL wrap_second got=%b exp=0100", a); end
    req = 4'b0;
    step();
    checks++; if (a_out !== 4'h7 || owner !== 2'd2) begin failures++; $display("FAIL wrap_second_A got=%h/%0d exp=7/2", a_out, owner); end
  endtask

  task automatic test_req_in_hold();
    logic [3:0] a; int n;
    req = 4'b0001; din = 16'h000E;
    wait_ack(a, n);
    checks++; if (a !== 4'b0001) begin failures++; $display("FAIL hold_setup_ack got=%b exp=0001", a); end
    req = 4'b0;
    step();
    req = 4'b1000; din = 16'hB00E;
    checks++; if (ack !== 4'b0 || busy !== 1'b1) begin failures++; $display("FAIL hold_c1 got=%b/%b exp=0/1", ack, busy); end
    step();
    checks++; if (ack !== 4'b0 || busy !== 1'b1) begin failures++; $display("FAIL hold_c2 got=%b/%b exp=0/1", ack, busy); end
    step();
    checks++; if (ack !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL hold_idle got=%b/%b exp=0/0", ack, busy); end
    step();
    checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL hold_ack3 got=%b exp=1000", ack); end
    req = 4'b0;
    step();
    checks++; if (a_out !== 4'hB || owner !== 2'd3) begin failures++; $display("FAIL hold_A got=%h/%0d exp=B/3", a_out, owner); end
  endtask

  task automatic test_reset_in_load();
    logic [3:0] a; int n;
    rst_pulse();
    req = 4'b0001; din = 16'h0005;
    wait_ack(a, n);
    checks++; if (a !== 4'b0001) begin failures++; $display("FAIL rl_setup_ack got=%b exp=0001", a); end
    req = 4'b0;
    step();
    checks++; if (a_out !== 4'h5 || owner !== 2'd0) begin failures++; $display("FAIL rl_setup_A got=%h/%0d exp=5/0", a_out, owner); end
    req = 4'b0100; din = 16'h0D05;
    wait_ack(a, n);
    checks++; if (a !== 4'b0100) begin failures++; $display("FAIL rl_ack2 got=%b exp=0100", a); end
    rst = 1'b1;
    #1;
    checks++; if (a_out !== 4'h0 || ack !== 4'b0) begin failures++; $display("FAIL rl_async got=%h/%b exp=0/0", a_out, ack); end
    checks++; if (owner !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL rl_owner got=%0d/%b exp=0/0", owner, busy); end
    rst = 1'b0;
    wait_ack(a, n);
    checks++; if (a !== 4'b0100 || n != 1) begin failures++; $display("FAIL rl_regrant got=%b/%0d exp=0100/1", a, n); end
    req = 4'b0;
    step();
    checks++; if (a_out !== 4'hD || owner !== 2'd2) begin failures++; $display("FAIL rl_A got=%h/%0d exp=D/2", a_out, owner); end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0;
    din = 16'h0;
    test_reset();
    test_single();
    test_rotation();
    test_fair_wrap();
    test_req_in_hold();
    test_reset_in_load();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
